uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART transmitter (uart_top TX path: dintx/send in, donetx out) among NUM_REQ byte-producing requesters. Arbitration is round-robin. The arbiter latches the winner's byte, drives dintx/send, holds send long enough for the slow baud-tick domain to sample it, then waits for donetx before granting again. It sits between the requester logic and uart_top, in the same clk domain.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 8, byte width; matches uart_top dintx
SEND_HOLD, 128, clk cycles tx_send is held high; must exceed one baud tick (1000000/9600 ≈ 104)
TIMEOUT_CYC, 2048, watchdog limit in clk cycles (used only with UART_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester byte pending
req_data  in  NUM_REQ*DATA_W  packed bytes; requester i occupies [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-hot, 1-cycle accept pulse; byte is latched on this cycle
done_pulse  out  NUM_REQ  one-hot, 1-cycle pulse when the granted byte finishes transmitting
tx_data  out  DATA_W  to uart_top dintx
tx_send  out  1  to uart_top send
tx_done  in  1  from uart_top donetx
busy  out  1  high in any state other than IDLE
grant_id  out  $clog2(NUM_REQ)  index of the current or last grantee
timeout_err  out  1  sticky watchdog flag (tied 0 without macro)

Behaviour:
- Reset (async, rst=1): state=IDLE; req_ready=0, done_pulse=0, tx_data=0, tx_send=0, busy=0, grant_id=0, timeout_err=0; RR pointer last=NUM_REQ-1, so requester 0 has first priority. Any in-flight transfer is abandoned without a done_pulse.
- tx_done is registered once. Completion event = rising edge of the registered tx_done (tx_done_q & ~tx_done_q2).
- FSM:
  - IDLE: if req_valid != 0, winner = first set bit scanning last+1, last+2, … modulo NUM_REQ. On that same edge: latch tx_data, set grant_id, pulse req_ready[winner], set tx_send=1, load hold counter = SEND_HOLD-1, go to SEND. Latency is 1 cycle from req_valid seen to req_ready/tx_send.
  - SEND: tx_send=1 and counts down. A completion event seen here is recorded in a flag. At count 0: tx_send=0; go to FINISH if the flag is set, else WAIT_DONE.
  - WAIT_DONE: tx_send=0; on completion event go to FINISH.
  - FINISH, 1 cycle: pulse done_pulse[grant_id], set last=grant_id, go to IDLE. No new grant happens in this cycle; the minimum gap between grants is SEND_HOLD+2 cycles.
- req_valid is sampled only in IDLE. Deasserting before grant withdraws the request with no side effects. req_data is only needed in the accept cycle.
- Same requester re-asserting immediately after done_pulse is granted only if no other requester is valid (fairness).
- tx_data holds its value until the next grant.
- Pointer wrap: last=NUM_REQ-1 scans from 0.

Optional Feature:
UART_ARB_TIMEOUT_EN
- With the macro: a watchdog counter runs in SEND and WAIT_DONE. If it reaches TIMEOUT_CYC without a completion event:
  - set timeout_err (sticky until rst);
  - go to FINISH anyway, so done_pulse still fires and arbitration continues.
- Without the macro: no counter; timeout_err is tied 0; WAIT_DONE waits indefinitely.

Decomposition:
- Package uart_arb_pkg:
  - state enum {IDLE, SEND, WAIT_DONE, FINISH};
  - localparam function for grant index width ($clog2 with min 1).
- Sub-module uart_rr_pick: combinational round-robin picker (req vector plus last pointer gives winner index and found flag). Instantiated once.

Test Plan:
- Reset, then req_valid=4'b0010 with byte 0x5A -> req_ready=0010 one cycle later; tx_data=0x5A; tx_send high exactly 128 cycles; done_pulse=0010 one cycle after the donetx edge; serial line shows 0x5A.
- req_valid=4'b1111 held, bytes 0x11/0x22/0x33/0x44 -> grants and UART output in order 0,1,2,3, then wraps to 0.
- Requesters 0 and 2 continuously valid -> grant sequence 0,2,0,2; never two consecutive grants to the same requester.
- rst asserted mid-WAIT_DONE -> all outputs 0 asynchronously; no done_pulse; the next grant after release goes to the lowest valid index.
- With UART_ARB_TIMEOUT_EN, tx_done stuck low -> timeout_err=1 at 2048 cycles after grant; done_pulse fires; the next request is still served; timeout_err stays 1.
- Request pulsed for 1 cycle while busy -> ignored; no req_ready, no transmission.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared FSM state encoding and sizing helper for the UART transmit arbiter.
package uart_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_SEND      = 2'd1;
    localparam state_t ST_WAIT_DONE = 2'd2;
    localparam state_t ST_FINISH    = 2'd3;

    // Bit width able to hold 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request after the last winner, wrapping.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [idx_w(NUM_REQ)-1:0]   last_i,
    output logic [idx_w(NUM_REQ)-1:0]   win_o,
    output logic                        found_o
);

    localparam int IW = idx_w(NUM_REQ);

    int          idx;
    logic [IW-1:0] cand;

    always_comb begin
        win_o   = '0;
        found_o = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = IW'(idx);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                win_o   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int SEND_HOLD   = 128,
    parameter int TIMEOUT_CYC = 2048
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          done_pulse,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_send,
    input  logic                        tx_done,
    output logic                        busy,
    output logic [idx_w(NUM_REQ)-1:0]   grant_id,
    output logic                        timeout_err
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = idx_w(SEND_HOLD);

    if (NUM_REQ < 2 || NUM_REQ > 16 || SEND_HOLD < 1 || TIMEOUT_CYC < 1) begin : g_param_chk
        $error("uart_tx_arbiter: parameter out of range");
    end

    state_t              state_q, state_d;
    logic [IW-1:0]       last_q, last_d;
    logic [IW-1:0]       grant_q, grant_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [NUM_REQ-1:0]  ready_q, ready_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                send_q, send_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                flag_q, flag_d;
    logic                txd_q, txd_q2;
    logic                done_evt;
    logic                wd_hit;
    logic                enter_fin;
    logic [IW-1:0]       pick_win;
    logic                pick_found;
    logic [DATA_W-1:0]   req_byte [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_byte[i] = req_data[i*DATA_W +: DATA_W];
    end

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i   (req_valid),
        .last_i  (last_q),
        .win_o   (pick_win),
        .found_o (pick_found)
    );

    // donetx comes from the slow baud domain logic; only its rising edge marks completion.
    assign done_evt = txd_q & ~txd_q2;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        data_d    = data_q;
        ready_d   = '0;
        done_d    = '0;
        send_d    = send_q;
        cnt_d     = cnt_q;
        flag_d    = flag_q;
        enter_fin = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d           = ST_SEND;
                    grant_d           = pick_win;
                    data_d            = req_byte[pick_win];
                    ready_d[pick_win] = 1'b1;
                    send_d            = 1'b1;
                    cnt_d             = CW'(SEND_HOLD - 1);
                    flag_d            = 1'b0;
                end
            end
            ST_SEND: begin
                // A completion can arrive while send is still held; remember it.
                flag_d = flag_q | done_evt;
                if (wd_hit) begin
                    enter_fin = 1'b1;
                end else if (cnt_q == '0) begin
                    send_d = 1'b0;
                    if (flag_q || done_evt) begin
                        enter_fin = 1'b1;
                    end else begin
                        state_d = ST_WAIT_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (done_evt || wd_hit) begin
                    enter_fin = 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (enter_fin) begin
            state_d         = ST_FINISH;
            send_d          = 1'b0;
            done_d[grant_q] = 1'b1;
            last_d          = grant_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= IW'(NUM_REQ - 1);
            grant_q <= '0;
            data_q  <= '0;
            ready_q <= '0;
            done_q  <= '0;
            send_q  <= 1'b0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            txd_q   <= 1'b0;
            txd_q2  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            send_q  <= send_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            txd_q   <= tx_done;
            txd_q2  <= txd_q;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int WDW = idx_w(TIMEOUT_CYC);

    logic [WDW-1:0] wd_q, wd_d;
    logic           terr_q;

    always_comb begin
        wd_d   = '0;
        wd_hit = 1'b0;
        if (state_q == ST_SEND || state_q == ST_WAIT_DONE) begin
            wd_d   = wd_q + 1'b1;
            wd_hit = !(done_evt || flag_q) && (wd_q == WDW'(TIMEOUT_CYC - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q   <= '0;
            terr_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            terr_q <= terr_q | wd_hit;
        end
    end

    assign timeout_err = terr_q;
`else
    assign wd_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign req_ready  = ready_q;
    assign done_pulse = done_q;
    assign tx_data    = data_q;
    assign tx_send    = send_q;
    assign busy       = (state_q != ST_IDLE);
    assign grant_id   = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant order, send hold, completion, reset, watchdog.
module tb_uart_tx_arbiter;

    localparam int NR   = 4;
    localparam int DW   = 8;
    localparam int HOLD = 128;
    localparam int TMO  = 2048;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     done_pulse;
    logic [DW-1:0]     tx_data;
    logic              tx_send;
    logic              tx_done;
    logic              busy;
    logic [1:0]        grant_id;
    logic              timeout_err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (NR),
        .DATA_W      (DW),
        .SEND_HOLD   (HOLD),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .done_pulse  (done_pulse),
        .tx_data     (tx_data),
        .tx_send     (tx_send),
        .tx_done     (tx_done),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] oh_idx(input logic [NR-1:0] v);
        logic [31:0] r;
        r = 0;
        for (int i = 0; i < NR; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    task automatic do_reset();
        req_valid = '0;
        tx_done   = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge with the DUT idle and requests already driven.
    task automatic xfer(input string tag, input logic [NR-1:0] exp_rdy, input logic [DW-1:0] exp_dat,
                        input bit early, input bit drop, input logic [NR-1:0] glitch);
        int            n_send;
        int            step;
        bit            saw_rdy;
        logic [NR-1:0] keep;
        @(negedge clk);
        check_val({tag, ".rdy"}, req_ready, exp_rdy);
        check_val({tag, ".dat"}, tx_data, exp_dat);
        check_val({tag, ".gid"}, grant_id, oh_idx(exp_rdy));
        check_val({tag, ".busy"}, busy, 1);
        n_send = tx_send ? 1 : 0;
        if (drop) begin
            req_valid = '0;
            req_data  = ~req_data;
        end
        keep    = req_valid;
        step    = 0;
        saw_rdy = 1'b0;
        while (tx_send && step < 400) begin
            @(negedge clk);
            step++;
            if (req_ready != '0) saw_rdy = 1'b1;
            if (tx_send) n_send++;
            if (step == 10 && early) tx_done = 1'b1;
            if (step == 12) tx_done = 1'b0;
            if (step == 20 && glitch != '0) req_valid = glitch;
            if (step == 21 && glitch != '0) req_valid = keep;
        end
        check_val({tag, ".hold"}, n_send, HOLD);
        check_val({tag, ".nordy"}, saw_rdy, 0);
        if (early) begin
            check_val({tag, ".done"}, done_pulse, exp_rdy);
        end else begin
            check_val({tag, ".wait"}, {busy, done_pulse}, 5'b10000);
            tx_done = 1'b1;
            @(negedge clk);
            check_val({tag, ".wait2"}, done_pulse, 0);
            @(negedge clk);
            check_val({tag, ".done"}, done_pulse, exp_rdy);
            tx_done = 1'b0;
        end
        @(negedge clk);
        check_val({tag, ".idle"}, {busy, done_pulse}, 0);
        check_val({tag, ".keep"}, tx_data, exp_dat);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        req_valid = '0;
        req_data  = '0;
        tx_done   = 1'b0;
        rst       = 1'b1;
        tick(3);
        check_val("rst.out", {req_ready, done_pulse, tx_data, tx_send, busy, grant_id, timeout_err}, 0);
        rst = 1'b0;

        // Single requester, completion after send drops.
        req_data  = {8'h44, 8'h33, 8'h5A, 8'h11};
        req_valid = 4'b0010;
        xfer("t1", 4'b0010, 8'h5A, 1'b0, 1'b1, 4'b0000);

        // All valid: 0,1,2,3 then wrap to 0.
        do_reset();
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b1111;
        xfer("t2a", 4'b0001, 8'h11, 1'b1, 1'b0, 4'b0000);
        xfer("t2b", 4'b0010, 8'h22, 1'b0, 1'b0, 4'b0000);
        xfer("t2c", 4'b0100, 8'h33, 1'b1, 1'b0, 4'b0000);
        xfer("t2d", 4'b1000, 8'h44, 1'b0, 1'b0, 4'b0000);
        xfer("t2e", 4'b0001, 8'h11, 1'b1, 1'b0, 4'b0000);

        // Requesters 0 and 2 alternate.
        do_reset();
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b0101;
        xfer("t3a", 4'b0001, 8'h11, 1'b0, 1'b0, 4'b0000);
        xfer("t3b", 4'b0100, 8'h33, 1'b1, 1'b0, 4'b0000);
        xfer("t3c", 4'b0001, 8'h11, 1'b1, 1'b0, 4'b0000);
        xfer("t3d", 4'b0100, 8'h33, 1'b0, 1'b0, 4'b0000);

        // Asynchronous reset while waiting for donetx.
        do_reset();
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b1000;
        @(negedge clk);
        check_val("t4.rdy", req_ready, 4'b1000);
        req_valid = '0;
        n = 0;
        while (tx_send && n < 400) begin
            @(negedge clk);
            n++;
        end
        tick(5);
        check_val("t4.wait", {busy, tx_send}, 2'b10);
        #2 rst = 1'b1;
        #1;
        check_val("t4.rst", {req_ready, done_pulse, tx_data, tx_send, busy, grant_id, timeout_err}, 0);
        @(negedge clk);
        rst     = 1'b0;
        tx_done = 1'b1;
        tick(2);
        tx_done = 1'b0;
        tick(2);
        check_val("t4.quiet", {busy, done_pulse}, 0);
        req_valid = 4'b1010;
        xfer("t4b", 4'b0010, 8'h22, 1'b0, 1'b1, 4'b0000);

        // One-cycle request from requester 2 while busy is ignored.
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b0001;
        xfer("t5", 4'b0001, 8'h11, 1'b1, 1'b1, 4'b0100);
        tick(3);
        check_val("t5.ign", {req_ready, busy}, 0);

        // A lone requester is re-granted back to back.
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b0100;
        xfer("t6a", 4'b0100, 8'h33, 1'b0, 1'b0, 4'b0000);
        xfer("t6b", 4'b0100, 8'h33, 1'b1, 1'b1, 4'b0000);

`ifdef UART_ARB_TIMEOUT_EN
        // donetx stuck low: watchdog fires, arbitration continues.
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b0001;
        @(negedge clk);
        check_val("t7.rdy", req_ready, 4'b0001);
        req_valid = '0;
        n = 0;
        while (!timeout_err && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_val("t7.cyc", n, TMO);
        check_val("t7.done", done_pulse, 4'b0001);
        @(negedge clk);
        check_val("t7.idle", busy, 0);
        req_valid = 4'b0010;
        xfer("t7b", 4'b0010, 8'h22, 1'b0, 1'b1, 4'b0000);
        check_val("t7.sticky", timeout_err, 1);
`else
        check_val("t7.tied", timeout_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
